hilo_muldiv_ctrl: RTL



---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/div_iter.sv | 72 +++++++
 rtl/hilo_muldiv_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller.
// Holds the controller state encoding, the divider iteration count and the
// bit positions used on the 2-bit MULT/DIV/MFHL/MTHL decode buses.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } state_t;

    // One quotient bit per cycle for a 32-bit dividend.
    localparam int DIV_ITER = 32;

    // MULT/DIV buses: [1] = unsigned form, [0] = signed form.
    localparam int OP_U = 1;
    localparam int OP_S = 0;
    // MFHL/MTHL buses: [1] = HI, [0] = LO.
    localparam int OP_HI = 1;
    localparam int OP_LO = 0;

    // Two's-complement negate when neg is set; used both to take operand
    // magnitudes before dividing and to restore signs afterwards.
    function automatic logic [31:0] cond_negate(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         load a/b and begin a new division (ignored if abort is high)
//   abort         drop any division in progress
//   a, b          dividend and divisor (unsigned magnitudes)
//   q, r          quotient/remainder after the current cycle's iteration
//   done          high in the cycle performing the final iteration, so q/r
//                 carry the finished result and can be captured on that edge
module div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        done
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [5:0]  cnt_q;
    logic        run_q;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The quotient register
    // doubles as the dividend shifter, so its vacated LSB takes the new
    // quotient bit. The result fits in 32 bits whenever the subtraction is
    // taken, so the low bits of the difference are all that is needed.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = shifted[31:0] - dvs_q;
        fits    = (shifted >= {1'b0, dvs_q});
        r       = fits ? diff : shifted[31:0];
        q       = {quo_q[30:0], fits};
        done    = run_q & (cnt_q == 6'(DIV_ITER - 1));
    end

    // Iteration registers: load on start, step while running, and stop
    // after the last iteration or on abort/reset.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= a;
            dvs_q <= b;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= r;
            quo_q <= q;
            cnt_q <= cnt_q + 6'd1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage.
// Accepts mult/div/mfhi/mflo/mthi/mtlo at issue, runs multiplies and divides
// in the background, owns HI/LO and stalls only HI/LO users that arrive
// while an operation is in flight.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   issue_valid         EX holds a valid, non-flushed instruction
//   MULT, DIV           [1]=unsigned [0]=signed multiply / divide
//   MFHL, MTHL          [1]=HI [0]=LO move-from / move-to
//   src_a, src_b        rs / rt operands
//   flush               abort in-flight operation, ignore this cycle's issue
//   stall               hold IF..EX this cycle
//   busy                operation in flight
//   hl_rdata            HI or LO selected by MFHL (0 if neither)
//   hi, lo              architectural HI/LO
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [1:0]  MULT,
    input  logic [1:0]  DIV,
    input  logic [1:0]  MFHL,
    input  logic [1:0]  MTHL,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hl_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q;
    logic [32:0] mul_a_q, mul_b_q;
    logic        div_sa_q, div_sb_q, div_zero_q;
    logic        any_op, issue_ok, acc_mul, acc_div;
    logic        mul_last, div_last;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] div_q, div_r, quo_fix, rem_fix;
    logic        div_done;

    // Control decode and next-state logic. An instruction is only taken
    // when the unit is idle and not being flushed; any HI/LO instruction
    // arriving while busy is held by stall until the cycle busy drops.
    always_comb begin
        state_d  = state_q;
        busy     = (state_q != IDLE);
        any_op   = |{MULT, DIV, MFHL, MTHL};
        stall    = issue_valid & ~flush & busy & any_op;
        issue_ok = issue_valid & ~flush & ~busy;
        acc_mul  = issue_ok & (|MULT);
        acc_div  = issue_ok & (|DIV);
        mul_last = 1'b0;
        div_last = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc_mul) begin
                    state_d = MUL_BUSY;
                end else if (acc_div) begin
                    state_d = DIV_BUSY;
                end
            end
            MUL_BUSY: begin
                if (cnt_q == 3'(MUL_LAT - 1)) begin
                    mul_last = 1'b1;
                    state_d  = IDLE;
                end
            end
            DIV_BUSY: begin
                if (div_done) begin
                    div_last = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Multiply latency counter: counts busy cycles so the result is
    // written on the edge ending busy cycle MUL_LAT.
    always_ff @(posedge clk) begin
        if (rst || flush || acc_mul || mul_last) begin
            cnt_q <= '0;
        end else if (state_q == MUL_BUSY) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    // Operand capture at acceptance. Multiply operands are held as 33-bit
    // values whose top bit is the sign for mult and zero for multu, so a
    // single signed product covers both forms. Divide keeps only the signs
    // and the divide-by-zero flag; the divider holds the magnitudes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            div_sa_q   <= 1'b0;
            div_sb_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            if (acc_mul) begin
                mul_a_q <= {MULT[OP_S] & src_a[31], src_a};
                mul_b_q <= {MULT[OP_S] & src_b[31], src_b};
            end
            if (acc_div) begin
                div_sa_q   <= DIV[OP_S] & src_a[31];
                div_sb_q   <= DIV[OP_S] & src_b[31];
                div_zero_q <= (src_b == 32'd0);
            end
        end
    end

    // Product of the held operands. Extending the 33-bit values to 64 bits
    // and keeping the low 64 product bits gives the exact signed/unsigned
    // result. Operands are stable for the whole busy window, so this path
    // has MUL_LAT cycles to settle before it is written.
    always_comb begin
        ext_a = {{31{mul_a_q[32]}}, mul_a_q};
        ext_b = {{31{mul_b_q[32]}}, mul_b_q};
        prod  = ext_a * ext_b;
    end

    div_iter u_div_iter (
        .clk   (clk),
        .rst   (rst),
        .start (acc_div),
        .abort (flush),
        .a     (cond_negate(src_a, DIV[OP_S] & src_a[31])),
        .b     (cond_negate(src_b, DIV[OP_S] & src_b[31])),
        .q     (div_q),
        .r     (div_r),
        .done  (div_done)
    );

    // Signed divide: quotient negative when operand signs differ,
    // remainder takes the dividend's sign.
    always_comb begin
        quo_fix = cond_negate(div_q, div_sa_q ^ div_sb_q);
        rem_fix = cond_negate(div_r, div_sa_q);
    end

    // HI/LO update. Completions and moves are mutually exclusive because
    // moves are only accepted while idle. A flush on the completion edge
    // suppresses the write, and a zero divisor never writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (mul_last && !flush) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
        end else if (div_last && !flush && !div_zero_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
        end else begin
            if (issue_ok && MTHL[OP_HI]) begin
                hi <= src_a;
            end
            if (issue_ok && MTHL[OP_LO]) begin
                lo <= src_a;
            end
        end
    end

    // Read port for mfhi/mflo straight from the registers.
    always_comb begin
        hl_rdata = MFHL[OP_HI] ? hi : (MFHL[OP_LO] ? lo : 32'd0);
    end

endmodule
